dvp_pattern_source: RTL
=======================

Name: dvp_pattern_source

Overview:
- Synthetic camera-side pixel transmitter: drives the same pclk/v_sync/h_ref/data_in interface the camera capture path consumes, in the OV7670-style QQVGA RGB565 byte format.
- Lets the capture → framebuffer → VGA chain run and be verified without a sensor.
- Instantiated beside the camera controller; a top-level mux selects sensor or source.

Parameters:
- H_ACTIVE, 160, active pixels per line
- V_ACTIVE, 120, active lines per frame
- BYTES_PER_PIXEL, 2, bytes per pixel (RGB565, high byte first)
- H_BLANK, 64, pclk periods with h_ref low per line
- VS_LINES, 3, line periods with v_sync high
- VBP_LINES, 17, blank lines after v_sync
- VFP_LINES, 10, blank lines after the last active line

Ports:
- clk_25  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled only at frame boundaries
- mode  in  2  0=colour bars, 1=grey ramp, 2=8x8 checker, 3=solid
- solid_color  in  16  RGB565 value used in mode 3
- pclk  out  1  pixel clock, clk_25/2
- v_sync  out  1  frame sync, active high
- h_ref  out  1  byte-valid line reference
- data_out  out  8  pixel byte
- frame_done  out  1  one-clk_25 pulse at the end of each frame
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset (synchronous, active-high) forces:
  - all outputs to 0
  - state IDLE
  - all counters to 0
  - pclk low
- Takes effect on the first clk_25 edge with reset high, including mid-frame.
- pclk: toggle register; runs only outside IDLE and is held 0 in IDLE.
  - A "slot" is one pclk period (2 clk_25 cycles).
  - v_sync, h_ref and data_out update only on the clk_25 edge where pclk goes 1→0, so they are stable at each pclk rising edge.
- Line = H_ACTIVE*BYTES_PER_PIXEL + H_BLANK slots (default 384).
  - In active lines, h_ref is high for the first 320 slots.
  - data_out is 0 whenever h_ref is low.
- States (line counter within state; slot counter within line):
  - IDLE: leaves when enable=1. Latches mode and solid_color, then → VSYNC.
  - VSYNC: v_sync=1 for VS_LINES lines → VBACK.
  - VBACK: VBP_LINES blank lines → ACTIVE.
  - ACTIVE: V_ACTIVE lines with h_ref → VFRONT.
  - VFRONT: VFP_LINES blank lines, then:
    - frame_done pulses for 1 clk_25.
    - If enable=1: relatch mode/solid_color → VSYNC.
    - Else → IDLE.
- Default frame length: 150 lines × 384 slots = 57600 slots = 115200 clk_25.
- enable dropping mid-frame has no effect until the frame completes.
- mode/solid_color changes mid-frame are ignored until the next latch.
- busy=1 in every state except IDLE.
- Pixel x (0..H_ACTIVE-1) = active slot/2; y = active line index.
- Even byte slot sends pixel[15:8]; odd byte slot sends pixel[7:0].
- Patterns:
  - mode 0: 8 bars, each H_ACTIVE/8 wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 1: R=x[7:3], G=x[7:2], B=x[7:3]; x is zero-extended to 8 bits.
  - mode 2: FFFF if x[3]^y[3]==0, else 0000.
  - mode 3: latched solid_color.
- All counters are sized by $clog2 of their maximum and wrap exactly at the terminal count, with no overrun.

Optional Feature:
- Macro: DVP_SRC_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count[15:0]: reset 0, +1 on each frame_done, wraps FFFF→0000.
  - Pixel (0,0) of each frame carries frame_count[15:0] in place of the pattern value.
- Undefined: no port, no counter; pixel (0,0) follows the pattern.

Decomposition:
- Package dvp_pkg:
  - state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT)
  - mode codes
  - the 8 RGB565 colour-bar constants
- Sub-module dvp_pattern_gen: combinational map (x, y, mode, solid_color) → 16-bit RGB565. Timing and FSM stay in the top module.

Test Plan:
- Reset mid-ACTIVE → next clk_25: pclk=0, h_ref=0, v_sync=0, data_out=00, busy=0. No output until enable is seen.
- enable=1, mode=0:
  - v_sync high for exactly 1152 slots, then 17×384 blank slots.
  - First active bytes FF,FF; pixel 20 bytes FF,E0; pixel 159 bytes 00,00.
  - h_ref high 320 slots, low 64 slots per line.
- mode=1 → pixel x=100 bytes 63,2C; x=0 bytes 00,00.
- mode=2:
  - (x=0,y=0) → FF,FF
  - (x=8,y=0) → 00,00
  - (x=8,y=8) → FF,FF
- enable dropped at line 50 of ACTIVE → frame completes; frame_done pulses once after 115200 clk_25 from frame start; then IDLE, pclk held 0.
- mode=3 with solid_color=1234; mode changed to 0 mid-frame → every active byte pair stays 12,34 until the next frame, which shows bars.
- DVP_SRC_FRAME_CNT_EN defined → frame_count = 0,1,2 across three frames; pixel (0,0) bytes equal the count.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and constants for the synthetic DVP pattern source:
// FSM states, pattern mode codes and the eight colour-bar values.
package dvp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBACK  = 3'd2,
      ACTIVE = 3'd3,
      VFRONT = 3'd4
   } state_t;

   localparam logic [1:0] MODE_BARS    = 2'd0;
   localparam logic [1:0] MODE_GREY    = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;
   localparam logic [1:0] MODE_SOLID   = 2'd3;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

   // Counter width for values 0..count-1, never narrower than min_w.
   function automatic int width_of(input int count, input int min_w);
      int w;
      w = $clog2(count);
      return (w < min_w) ? min_w : w;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern generator: maps pixel coordinate, mode and
// solid colour to one RGB565 pixel value.
module dvp_pattern_gen
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE = 160,
   parameter int XW       = 8,
   parameter int YW       = 7
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [1:0]    mode,
   input  logic [15:0]   solid_color,
   output logic [15:0]   pixel
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [6:0]  past_edge;
   logic [2:0]  bar_idx;
   logic [7:0]  x8;
   logic        checker_dark;

   // Thermometer code of the bar boundaries the pixel has crossed.
   for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
      assign past_edge[gi] = (32'(x) >= 32'((gi + 1) * BAR_W));
   end

   always_comb begin
      bar_idx = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (past_edge[i]) bar_idx = 3'(i + 1);
      end
   end

   assign x8           = x[7:0];
   assign checker_dark = ((((32'(x) >> 3) ^ (32'(y) >> 3)) & 32'd1) != 32'd0);

   always_comb begin
      case (mode)
         MODE_BARS:    pixel = bar_color(bar_idx);
         MODE_GREY:    pixel = {x8[7:3], x8[7:2], x8[7:3]};
         MODE_CHECKER: pixel = checker_dark ? 16'h0000 : 16'hFFFF;
         default:      pixel = solid_color;
      endcase
   end

endmodule

// File: rtl/dvp_pattern_source.sv
// Synthetic OV7670-style DVP transmitter (QQVGA RGB565, pclk = clk_25/2).
// Optional build macro DVP_SRC_FRAME_CNT_EN adds frame_count and stamps it on pixel (0,0).
module dvp_pattern_source
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE        = 160,
   parameter int V_ACTIVE        = 120,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int H_BLANK         = 64,
   parameter int VS_LINES        = 3,
   parameter int VBP_LINES       = 17,
   parameter int VFP_LINES       = 10
) (
   input  logic        clk_25,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [15:0] solid_color,
   output logic        pclk,
   output logic        v_sync,
   output logic        h_ref,
   output logic [7:0]  data_out,
   output logic        frame_done,
   output logic        busy
`ifdef DVP_SRC_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int ACTIVE_SLOTS = H_ACTIVE * BYTES_PER_PIXEL;
   localparam int LINE_SLOTS   = ACTIVE_SLOTS + H_BLANK;
   localparam int MAX_LINES    = max4(VS_LINES, VBP_LINES, V_ACTIVE, VFP_LINES);
   localparam int SW           = width_of(LINE_SLOTS, 1);
   localparam int LW           = width_of(MAX_LINES, 1);
   localparam int XW           = width_of(H_ACTIVE, 8);
   localparam int YW           = width_of(V_ACTIVE, 4);

   localparam logic [SW-1:0] SLOT_LAST  = SW'(LINE_SLOTS - 1);
   localparam logic [SW-1:0] ACTIVE_END = SW'(ACTIVE_SLOTS);

   state_t          state_reg, state_next;
   logic [SW-1:0]   slot_reg, slot_next;
   logic [LW-1:0]   line_reg, line_next;
   logic [LW-1:0]   line_last;
   logic            pclk_reg;
   logic [1:0]      mode_reg;
   logic [15:0]     solid_reg;
   logic            v_sync_reg, h_ref_reg, frame_done_reg, busy_reg;
   logic [7:0]      data_reg;
   logic            v_sync_next, h_ref_next, busy_next;
   logic [7:0]      data_next;
   logic            adv, last_slot, last_line, frame_end, latch;
   logic [XW-1:0]   x_next;
   logic [YW-1:0]   y_next;
   logic [15:0]     pattern_pixel, pixel_sel;
`ifdef DVP_SRC_FRAME_CNT_EN
   logic [15:0]     frame_cnt_reg;
`endif

   // Timing advances once per slot, on the edge where pclk falls; in IDLE the
   // first slot starts on the edge that sees enable.
   assign adv       = (state_reg == IDLE) ? enable : pclk_reg;
   assign last_slot = (slot_reg == SLOT_LAST);
   assign last_line = (line_reg == line_last);
   assign frame_end = pclk_reg && (state_reg == VFRONT) && last_slot && last_line;
   assign latch     = enable && ((state_reg == IDLE) || frame_end);

   always_comb begin
      case (state_reg)
         VSYNC:   line_last = LW'(VS_LINES - 1);
         VBACK:   line_last = LW'(VBP_LINES - 1);
         ACTIVE:  line_last = LW'(V_ACTIVE - 1);
         default: line_last = LW'(VFP_LINES - 1);
      endcase
   end

   always_comb begin
      state_next = state_reg;
      slot_next  = slot_reg;
      line_next  = line_reg;
      if (adv) begin
         if (state_reg == IDLE) begin
            state_next = VSYNC;
            slot_next  = '0;
            line_next  = '0;
         end else begin
            slot_next = last_slot ? '0 : slot_reg + 1'b1;
            if (last_slot) begin
               if (last_line) begin
                  line_next = '0;
                  case (state_reg)
                     VSYNC:   state_next = VBACK;
                     VBACK:   state_next = ACTIVE;
                     ACTIVE:  state_next = VFRONT;
                     default: state_next = enable ? VSYNC : IDLE;
                  endcase
               end else begin
                  line_next = line_reg + 1'b1;
               end
            end
         end
      end
   end

   assign x_next = XW'(slot_next >> 1);
   assign y_next = YW'(line_next);

   dvp_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW),
      .YW       (YW)
   ) u_pattern_gen (
      .x           (x_next),
      .y           (y_next),
      .mode        (mode_reg),
      .solid_color (solid_reg),
      .pixel       (pattern_pixel)
   );

   // Outputs are computed for the slot about to start and registered on adv.
   always_comb begin
      pixel_sel = pattern_pixel;
`ifdef DVP_SRC_FRAME_CNT_EN
      if ((x_next == '0) && (y_next == '0)) pixel_sel = frame_cnt_reg;
`endif
      v_sync_next = (state_next == VSYNC);
      h_ref_next  = (state_next == ACTIVE) && (slot_next < ACTIVE_END);
      busy_next   = (state_next != IDLE);
      data_next   = 8'h00;
      if (h_ref_next) data_next = slot_next[0] ? pixel_sel[7:0] : pixel_sel[15:8];
   end

   always_ff @(posedge clk_25) begin
      if (reset) begin
         state_reg <= IDLE;
         slot_reg  <= '0;
         line_reg  <= '0;
         pclk_reg  <= 1'b0;
         mode_reg  <= 2'd0;
         solid_reg <= 16'h0000;
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         line_reg  <= line_next;
         pclk_reg  <= (state_reg == IDLE) ? 1'b0 : ~pclk_reg;
         if (latch) begin
            mode_reg  <= mode;
            solid_reg <= solid_color;
         end
      end
   end

   always_ff @(posedge clk_25) begin
      if (reset) begin
         v_sync_reg     <= 1'b0;
         h_ref_reg      <= 1'b0;
         data_reg       <= 8'h00;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= frame_end;
         if (adv) begin
            v_sync_reg <= v_sync_next;
            h_ref_reg  <= h_ref_next;
            data_reg   <= data_next;
            busy_reg   <= busy_next;
         end
      end
   end

`ifdef DVP_SRC_FRAME_CNT_EN
   always_ff @(posedge clk_25) begin
      if (reset) begin
         frame_cnt_reg <= 16'h0000;
      end else if (frame_end) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

   assign frame_count = frame_cnt_reg;
`endif

   assign pclk       = pclk_reg;
   assign v_sync     = v_sync_reg;
   assign h_ref      = h_ref_reg;
   assign data_out   = data_reg;
   assign frame_done = frame_done_reg;
   assign busy       = busy_reg;

endmodule
